// File: rtl/rom_stream_loader.sv
// rom_stream_loader
// Memory-mapped ROM-load streamer on the PicoRV32 I/O bus. Firmware writes
// 32-bit words to DATA. They queue in a word FIFO and leave as a little-endian
// valid/ready byte (or halfword) stream towards the cart loader. A DATA write
// that finds the FIFO full is held off (bus_ready low), so no data is lost.
// Registers: CTRL=+0, DATA=+4, STATUS=+8, CSUM=+C (bus_addr[1:0] ignored).
// Optional build macro: ROMLOAD_CHECKSUM_EN adds a 16-bit running sum of the
// accepted output bytes. Without it, CSUM reads as zero.

module rom_stream_loader #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          OUT_BYTES  = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0030
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   bus_valid,
    input  logic [31:0]            bus_addr,
    input  logic [31:0]            bus_wdata,
    input  logic [3:0]             bus_wstrb,
    output logic                   bus_sel,
    output logic                   bus_ready,
    output logic [31:0]            bus_rdata,
    output logic                   rom_loading,
    output logic [8*OUT_BYTES-1:0] rom_do,
    output logic                   rom_do_valid,
    input  logic                   rom_do_ready
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OUT_W = 8 * OUT_BYTES;
    localparam int BEATS = 4 / OUT_BYTES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_DATA   = 2'd1,
        REG_STATUS = 2'd2,
        REG_CSUM   = 2'd3
    } reg_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    reg_e offset;
    logic is_write;
    logic ctrl_wr;
    logic data_wr;
    logic start;
    logic finish_req;
    logic push;
    logic unused_addr_bits;

    // Word-level offset within the window; byte-lane bits are ignored.
    assign offset           = reg_e'(bus_addr[3:2]);
    assign unused_addr_bits = ^bus_addr[1:0];
    assign is_write         = |bus_wstrb;

    // Window match on the upper address bits; the window is 16-byte aligned.
    assign bus_sel    = bus_valid && (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign ctrl_wr    = bus_sel && is_write && (offset == REG_CTRL);
    assign data_wr    = bus_sel && is_write && (offset == REG_DATA);
    assign start      = ctrl_wr && (bus_wdata[7:0] == 8'h01);
    assign finish_req = ctrl_wr && (bus_wdata[7:0] == 8'h00);

    // FIFO storage and pointers (extra MSB separates full from empty).
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fifo_level;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_level = wr_ptr - rd_ptr;

    // A full FIFO holds the CPU off only while loading; otherwise DATA is
    // acknowledged and discarded.
    assign bus_ready = bus_sel && !(data_wr && fifo_full && rom_loading);
    assign push      = data_wr && rom_loading && !fifo_full;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Pointer update; start flushes the queue along with reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!resetn || start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Word storage written on each accepted DATA push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers alone decide
        // which entries are meaningful, and a reset would block RAM mapping.
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus_wdata;
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    ser_state_e state;
    ser_state_e state_next;
    logic [31:0]   shift_reg;
    logic [BW-1:0] beat_cnt;
    logic          beat_xfer;
    logic          last_xfer;
    logic          load;

    assign beat_xfer = rom_do_valid && rom_do_ready;
    assign last_xfer = beat_xfer && (beat_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn || start) state <= ST_IDLE;
        else                  state <= state_next;
    end

    // Next state: leave IDLE when a word is queued, return only when the last
    // beat goes out with nothing behind it.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_SHIFT;
            ST_SHIFT: if (last_xfer && fifo_empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs: valid while shifting; pop a word when idle or on the last
    // beat so consecutive words stream without a bubble.
    always_comb begin
        rom_do_valid = 1'b0;
        load         = 1'b0;
        case (state)
            ST_IDLE:  load = !fifo_empty;
            ST_SHIFT: begin
                rom_do_valid = 1'b1;
                load         = last_xfer && !fifo_empty;
            end
            default: ;
        endcase
    end

    assign pop    = load;
    assign rom_do = shift_reg[OUT_W-1:0];

    // Shift register: load a word, then move one beat down per transfer.
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            shift_reg <= '0;
            beat_cnt  <= '0;
        end else if (load) begin
            shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
            beat_cnt  <= '0;
        end else if (beat_xfer) begin
            shift_reg <= shift_reg >> OUT_W;
            beat_cnt  <= beat_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte counter, checksum, control state
    // ------------------------------------------------------------------
    logic [23:0] bytes_out;
    logic [15:0] csum_value;

    // Count of accepted output bytes since start; wraps at 2^24.
    always_ff @(posedge clk) begin
        if (!resetn || start)  bytes_out <= '0;
        else if (beat_xfer)    bytes_out <= bytes_out + 24'(OUT_BYTES);
    end

`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0] beat_sum;
    logic [15:0] csum;

    // Sum of the bytes in the beat currently on rom_do.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            beat_sum = beat_sum + 16'(rom_do[8*i +: 8]);
        end
    end

    // Running checksum of accepted bytes, modulo 2^16.
    always_ff @(posedge clk) begin
        if (!resetn || start) csum <= '0;
        else if (beat_xfer)   csum <= csum + beat_sum;
    end

    assign csum_value = csum;
`else
    assign csum_value = 16'h0000;
`endif

    logic finish_pend;
    logic drain_done;

    // Stream fully drained: nothing queued, nothing arriving, serialiser
    // returning to (or sitting in) IDLE.
    assign drain_done = finish_pend && fifo_empty && !push && (state_next == ST_IDLE);

    // rom_loading / finish_pend: start raises loading; finish waits for drain.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rom_loading <= 1'b0;
            finish_pend <= 1'b0;
        end else if (start) begin
            rom_loading <= 1'b1;
            finish_pend <= 1'b0;
        end else if (finish_req) begin
            finish_pend <= 1'b1;
        end else if (drain_done) begin
            rom_loading <= 1'b0;
            finish_pend <= 1'b0;
        end
    end

    // Read mux; DATA reads as zero.
    always_comb begin
        bus_rdata = 32'h0;
        if (bus_sel && !is_write) begin
            case (offset)
                REG_CTRL:   bus_rdata = {8'h00, 8'(fifo_level), 13'h0000,
                                         finish_pend, rom_do_valid, rom_loading};
                REG_STATUS: bus_rdata = {8'h00, bytes_out};
                REG_CSUM:   bus_rdata = {16'h0000, csum_value};
                default:    bus_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_loader.sv
// tb_rom_stream_loader
// Two instances: A (FIFO_DEPTH=4, OUT_BYTES=1) and B (FIFO_DEPTH=16,
// OUT_BYTES=2). Expected beats are queued as writes are issued; a monitor
// per instance pops and compares each accepted beat. Checksum expectations
// follow ROMLOAD_CHECKSUM_EN.

module tb_rom_stream_loader;

    localparam logic [31:0] BASE     = 32'h0200_0030;
    localparam logic [31:0] O_CTRL   = 32'h0;
    localparam logic [31:0] O_DATA   = 32'h4;
    localparam logic [31:0] O_STATUS = 32'h8;
    localparam logic [31:0] O_CSUM   = 32'hC;

`ifdef ROMLOAD_CHECKSUM_EN
    localparam logic [31:0] CSUM_A_EXP = 32'h0000_0201;
    localparam logic [31:0] CSUM_B_EXP = 32'h0000_030E;
`else
    localparam logic [31:0] CSUM_A_EXP = 32'h0;
    localparam logic [31:0] CSUM_B_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        bus_valid [2];
    logic [31:0] bus_addr  [2];
    logic [31:0] bus_wdata [2];
    logic [3:0]  bus_wstrb [2];
    logic        bus_sel   [2];
    logic        bus_ready [2];
    logic [31:0] bus_rdata [2];

    logic        rom_loading_a, rom_valid_a, rom_ready_a;
    logic [7:0]  rom_do_a;
    logic        rom_loading_b, rom_valid_b, rom_ready_b;
    logic [15:0] rom_do_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_a [$];
    logic [15:0] exp_b [$];
    logic [7:0]  e_a;
    logic [15:0] e_b;
    bit          done6;

    rom_stream_loader #(.FIFO_DEPTH(4), .OUT_BYTES(1), .BASE_ADDR(BASE)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .bus_valid(bus_valid[0]), .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
        .bus_wstrb(bus_wstrb[0]), .bus_sel(bus_sel[0]), .bus_ready(bus_ready[0]),
        .bus_rdata(bus_rdata[0]), .rom_loading(rom_loading_a), .rom_do(rom_do_a),
        .rom_do_valid(rom_valid_a), .rom_do_ready(rom_ready_a)
    );

    rom_stream_loader #(.FIFO_DEPTH(16), .OUT_BYTES(2), .BASE_ADDR(BASE)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .bus_valid(bus_valid[1]), .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
        .bus_wstrb(bus_wstrb[1]), .bus_sel(bus_sel[1]), .bus_ready(bus_ready[1]),
        .bus_rdata(bus_rdata[1]), .rom_loading(rom_loading_b), .rom_do(rom_do_b),
        .rom_do_valid(rom_valid_b), .rom_do_ready(rom_ready_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (resetn && rom_valid_a && rom_ready_a) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_a: unexpected beat %h with empty queue", rom_do_a);
            end else begin
                e_a = exp_a.pop_front();
                check("beat_a", 32'(rom_do_a), 32'(e_a));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (resetn && rom_valid_b && rom_ready_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_b: unexpected beat %h with empty queue", rom_do_b);
            end else begin
                e_b = exp_b.pop_front();
                check("beat_b", 32'(rom_do_b), 32'(e_b));
            end
        end
    end

    // One bus access; returns at posedge+1 after the handshake edge.
    task automatic bus_access(input int d, input logic [31:0] offs, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int budget,
                              output logic [31:0] rdata, output bit ok);
        @(posedge clk); #1;
        bus_valid[d] = 1'b1;
        bus_addr[d]  = BASE + offs;
        bus_wdata[d] = wdata;
        bus_wstrb[d] = wstrb;
        ok    = 1'b0;
        rdata = 32'h0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_ready[d]) begin
                rdata = bus_rdata[d];
                ok    = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus_valid[d] = 1'b0;
        bus_wstrb[d] = 4'h0;
    endtask

    task automatic wr(input int d, input logic [31:0] offs, input logic [31:0] data, input string name);
        logic [31:0] r;
        bit ok;
        bus_access(d, offs, data, 4'hF, 20, r, ok);
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic rd(input int d, input logic [31:0] offs, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bit ok;
        bus_access(d, offs, 32'h0, 4'h0, 20, r, ok);
        check(name, ok ? r : 32'hxxxx_xxxx, exp);
    endtask

    task automatic push_word_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_a.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_valid(input int d, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ((d == 0) ? rom_valid_a : rom_valid_b) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input int d, input string name);
        bit drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d == 0 && exp_a.size() == 0 && !rom_valid_a) begin drained = 1'b1; break; end
            if (d == 1 && exp_b.size() == 0 && !rom_valid_b) begin drained = 1'b1; break; end
        end
        @(posedge clk); #1;
        check(name, 32'(drained), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] r6;
        bit ok6;
        int cnt;
        bit fell;

        for (int i = 0; i < 2; i++) begin
            bus_valid[i] = 1'b0;
            bus_addr[i]  = 32'h0;
            bus_wdata[i] = 32'h0;
            bus_wstrb[i] = 4'h0;
        end
        rom_ready_a = 1'b0;
        rom_ready_b = 1'b0;
        resetn      = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state.
        check("rst_valid_a", 32'(rom_valid_a), 32'd0);
        check("rst_loading_a", 32'(rom_loading_a), 32'd0);
        check("rst_do_a", 32'(rom_do_a), 32'd0);
        check("rst_do_b", 32'(rom_do_b), 32'd0);
        rd(0, O_CTRL, 32'h0, "rst_ctrl");
        rd(0, O_STATUS, 32'h0, "rst_status");
        rd(0, O_CSUM, 32'h0, "rst_csum");

        // Window decode edges.
        bus_valid[0] = 1'b1;
        bus_addr[0]  = BASE + 32'h10;
        #1 check("sel_above", 32'(bus_sel[0]), 32'd0);
        bus_addr[0]  = BASE + 32'hF;
        #1 check("sel_top", 32'(bus_sel[0]), 32'd1);
        bus_addr[0]  = BASE - 32'h1;
        #1 check("sel_below", 32'(bus_sel[0]), 32'd0);
        bus_valid[0] = 1'b0;

        // Test 1: single word, ready=1, latency N+2 and 4 back-to-back beats.
        rom_ready_a = 1'b1;
        wr(0, O_CTRL, 32'h1, "t1_start");
        rd(0, O_CTRL, 32'h1, "t1_ctrl");
        push_word_a(32'h4433_2211);
        wr(0, O_DATA, 32'h4433_2211, "t1_data");
        @(negedge clk) check("t1_lat_n1", 32'(rom_valid_a), 32'd0);
        @(negedge clk) check("t1_lat_n2", 32'(rom_valid_a), 32'd1);
        repeat (3) @(negedge clk) check("t1_beats", 32'(rom_valid_a), 32'd1);
        @(negedge clk) check("t1_end", 32'(rom_valid_a), 32'd0);
        rd(0, O_STATUS, 32'd4, "t1_status");
        rd(0, O_DATA, 32'h0, "t1_data_rd");

        // Test 6: checksum over 01,02,FF,FF; restart clears it.
        wr(0, O_CTRL, 32'h1, "t6_start");
        push_word_a(32'hFFFF_0201);
        wr(0, O_DATA, 32'hFFFF_0201, "t6_data");
        wait_drain(0, "t6_drain");
        rd(0, O_CSUM, CSUM_A_EXP, "t6_csum");
        wr(0, O_CTRL, 32'h1, "t6_restart");
        rd(0, O_CSUM, 32'h0, "t6_csum_clr");

        // Test 3: depth 4, ready=0; five writes fit, sixth stalls.
        rom_ready_a = 1'b0;
        wr(0, O_CTRL, 32'h1, "t3_start");
        for (int i = 0; i < 5; i++) begin
            w = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
            push_word_a(w);
            wr(0, O_DATA, w, "t3_fill");
        end
        rd(0, O_CTRL, 32'h0004_0003, "t3_ctrl_full");
        w = 32'h0302_0100 + 32'd5 * 32'h0404_0404;
        push_word_a(w);
        done6 = 1'b0;
        fork
            begin
                bus_access(0, O_DATA, w, 4'hF, 200, r6, ok6);
                done6 = 1'b1;
            end
            begin
                repeat (6) @(negedge clk);
                check("t3_stall_ready", 32'(bus_ready[0]), 32'd0);
                check("t3_stall_done", 32'(done6), 32'd0);
                @(posedge clk); #1;
                rom_ready_a = 1'b1;
            end
        join
        check("t3_sixth_ack", 32'(ok6), 32'd1);
        wait_drain(0, "t3_drain");
        rd(0, O_STATUS, 32'd24, "t3_status");

        // Test 4: finish with two words queued.
        rom_ready_a = 1'b0;
        wr(0, O_CTRL, 32'h1, "t4_start");
        push_word_a(32'hA3A2_A1A0);
        wr(0, O_DATA, 32'hA3A2_A1A0, "t4_data0");
        push_word_a(32'hA7A6_A5A4);
        wr(0, O_DATA, 32'hA7A6_A5A4, "t4_data1");
        wr(0, O_CTRL, 32'h0, "t4_finish");
        rd(0, O_CTRL, 32'h0001_0007, "t4_ctrl_pend");
        rom_ready_a = 1'b1;
        cnt  = 0;
        fell = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cnt == 8) begin
                check("t4_fall", 32'(rom_loading_a), 32'd0);
                check("t4_fall_valid", 32'(rom_valid_a), 32'd0);
                fell = 1'b1;
                break;
            end
            if (rom_valid_a) begin
                check("t4_hold", 32'(rom_loading_a), 32'd1);
                cnt++;
            end
        end
        check("t4_done", 32'(fell), 32'd1);
        @(posedge clk); #1;
        rd(0, O_CTRL, 32'h0, "t4_ctrl_idle");
        rd(0, O_STATUS, 32'd8, "t4_status");

        // Test 5: reset mid-word after two of four bytes.
        rom_ready_a = 1'b0;
        wr(0, O_CTRL, 32'h1, "t5_start");
        exp_a.push_back(8'h55);
        exp_a.push_back(8'h66);
        wr(0, O_DATA, 32'h8877_6655, "t5_data");
        wait_valid(0, "t5_valid");
        rom_ready_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rom_ready_a = 1'b0;
        resetn      = 1'b0;
        @(posedge clk); #1;
        check("t5_valid_clr", 32'(rom_valid_a), 32'd0);
        check("t5_loading_clr", 32'(rom_loading_a), 32'd0);
        check("t5_do_clr", 32'(rom_do_a), 32'd0);
        resetn = 1'b1;
        rd(0, O_STATUS, 32'h0, "t5_status");
        wr(0, O_DATA, 32'hDEAD_BEEF, "t5_drop_ack");
        repeat (4) @(negedge clk);
        check("t5_drop_valid", 32'(rom_valid_a), 32'd0);
        rd(0, O_CTRL, 32'h0, "t5_ctrl");

        // Test 2: 16-bit beats, rom_do held while ready=0.
        rom_ready_b = 1'b0;
        wr(1, O_CTRL, 32'h1, "t2_start");
        exp_b.push_back(16'hBBAA);
        exp_b.push_back(16'hDDCC);
        wr(1, O_DATA, 32'hDDCC_BBAA, "t2_data");
        wait_valid(1, "t2_valid");
        check("t2_first", 32'(rom_do_b), 32'h0000_BBAA);
        repeat (3) begin
            @(posedge clk); #1;
            check("t2_hold", {15'h0, rom_valid_b, rom_do_b}, 32'h0001_BBAA);
        end
        rom_ready_b = 1'b1;
        wait_drain(1, "t2_drain");
        rd(1, O_STATUS, 32'd4, "t2_status");
        rd(1, O_CSUM, CSUM_B_EXP, "t2_csum");

        check("left_a", 32'(exp_a.size()), 32'd0);
        check("left_b", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
